// File: rtl/morse_pkg.sv
// morse_pkg: shared Morse pattern types, FSM states and the A-H letter table
package morse_pkg;
  localparam int MORSE_BITS = 12;
  typedef logic [MORSE_BITS-1:0] morse_pat_t;
  typedef logic [2:0] letter_t;
  typedef enum logic [1:0] {IDLE, SYNC, SAMPLE, DECODE} dec_state_t;
  localparam morse_pat_t MORSE_TABLE [8] = '{
    12'b101110000000, 12'b111010101000, 12'b111010111010, 12'b111010100000,
    12'b100000000000, 12'b101011101000, 12'b111011101000, 12'b101010100000
  };
endpackage

// File: rtl/morse_bit_timer.sv
// morse_bit_timer: loadable down-counter, tick while the count is zero
module morse_bit_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign tick = cnt == '0;
endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: mid-bit sampling Morse receiver for letters A-H.
// Define MORSE_DEC_EARLY_END_EN to end a letter after three consecutive 0 samples.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 500
) (
  input  logic    ClockIn,
  input  logic    Reset,
  input  logic    DotDashIn,
  output letter_t LetterOut,
  output logic    ValidOut,
  output logic    ErrorOut,
  output logic    BusyOut
);
  localparam int P = CLOCK_FREQUENCY / 2;
  localparam int H = P / 2;
  localparam int TW = $clog2(P);
  dec_state_t state, state_n;
  logic prev, rise, tick, load, last, early, match;
  logic [TW-1:0] load_val;
  logic [3:0] bit_cnt;
  morse_pat_t shreg, shifted;
  letter_t code;
  morse_bit_timer #(.W(TW)) u_timer (
    .clk(ClockIn), .rst(Reset), .load(load), .load_val(load_val), .tick(tick)
  );
  assign rise = DotDashIn & ~prev;
  assign shifted = {shreg[MORSE_BITS-2:0], DotDashIn};
`ifdef MORSE_DEC_EARLY_END_EN
  // the leading bit is always 1, so two stored zeros plus this one is a real gap
  assign early = ~DotDashIn & ~shreg[1] & ~shreg[0];
`else
  assign early = 1'b0;
`endif
  assign last = bit_cnt == 4'd11 || early;
  assign BusyOut = state != IDLE;
  always_comb begin
    state_n = state;
    load = 1'b0;
    load_val = TW'(P - 1);
    case (state)
      IDLE: if (rise) begin
        state_n = SYNC;
        load = 1'b1;
        load_val = TW'(H - 1);
      end
      SYNC: if (tick) begin
        state_n = DotDashIn ? SAMPLE : IDLE;
        load = 1'b1;
      end
      SAMPLE: if (tick) begin
        state_n = last ? DECODE : SAMPLE;
        load = 1'b1;
      end
      DECODE: state_n = IDLE;
    endcase
  end
  always_comb begin
    match = 1'b0;
    code = '0;
    for (int i = 0; i < 8; i++)
      if (shreg == MORSE_TABLE[i]) begin
        match = 1'b1;
        code = letter_t'(i);
      end
  end
  always_ff @(posedge ClockIn)
    if (Reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge ClockIn)
    if (Reset) begin
      prev <= 1'b0;
      shreg <= '0;
      bit_cnt <= '0;
      LetterOut <= '0;
      ValidOut <= 1'b0;
      ErrorOut <= 1'b0;
    end else begin
      prev <= DotDashIn;
      ValidOut <= state == DECODE && match;
      ErrorOut <= state == DECODE && !match;
      if (state == DECODE && match) LetterOut <= code;
      if (state == SYNC && tick) begin
        shreg <= MORSE_BITS'(DotDashIn);
        bit_cnt <= 4'd1;
      end else if (state == SAMPLE && tick) begin
        shreg <= early ? shifted << (4'd11 - bit_cnt) : shifted;
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
endmodule
